// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases them one at a time
// in index order, waiting for each domain's ready acknowledge plus a fixed gap.
// A missing acknowledge re-asserts every reset and raises a sticky err.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_HOLD     | all resets asserted, counting the minimum hold time
// S_WAIT_RDY | domain seq_idx released, waiting for domain_ready[seq_idx]
// S_GAP      | acknowledge accepted, counting the gap before the next release
// S_DONE     | every domain released and acknowledged
// S_ERR      | acknowledge timeout, all resets re-asserted until restart
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8,
    localparam int IDX_W         = $clog2(NUM_DOMAINS) + 1
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   req_rst,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [IDX_W-1:0]       seq_idx
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_RDY,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    // Terminal counts: the transition fires on the edge where cnt == N-1.
    localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_inc;
    logic [NUM_DOMAINS-1:0]   ready_shift;
    logic                     ready_cur;

    // Saturating increment and selection of the acknowledge for the active domain.
    always_comb begin
        cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        ready_shift = domain_ready >> seq_idx;
        ready_cur   = ready_shift[0];
    end

    // Sequencer FSM; restart request behaves exactly like the synchronous reset.
    // Releases shift a zero in from the bottom, so domains free up in index order.
    always_ff @(posedge clk) begin
        if (sync_rst || req_rst) begin
            state   <= S_HOLD;
            cnt     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            seq_idx <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_TC) begin
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                        state   <= S_WAIT_RDY;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WAIT_RDY: begin
                    if (ready_cur) begin
                        cnt <= '0;
                        if (seq_idx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (cnt == TIMEOUT_TC) begin
                        state   <= S_ERR;
                        rst_out <= '1;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_TC) begin
                        seq_idx <= seq_idx + 1'b1;
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                        state   <= S_WAIT_RDY;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DONE: begin
                    rst_out <= '0;
                end
                S_ERR: begin
                    rst_out <= '1;
                end
                default: begin
                    state   <= S_ERR;
                    rst_out <= '1;
                    err     <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a behavioural model tracks how many
// domains are released and derives the expected outputs after every edge.
module tb_rst_seq_ctrl;

    localparam int N       = 4;
    localparam int HOLD    = 8;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 64;
    localparam int IW      = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          sync_rst = 1'b1;
    logic          req_rst = 1'b0;
    logic [N-1:0]  domain_ready = '0;
    logic [N-1:0]  rst_out;
    logic          busy, done, err;
    logic [IW-1:0] seq_idx;

    rst_seq_ctrl #(
        .NUM_DOMAINS(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)
    ) dut (
        .clk(clk), .sync_rst(sync_rst), .req_rst(req_rst),
        .domain_ready(domain_ready), .rst_out(rst_out), .busy(busy),
        .done(done), .err(err), .seq_idx(seq_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  rst;
        logic          busy;
        logic          done;
        logic          err;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: phase plus elapsed-cycle counters and a released-domain count.
    localparam int P_HOLD = 0, P_WAIT = 1, P_GAP = 2, P_DONE = 3, P_ERR = 4;
    int  m_phase, m_elapsed, m_nrel, m_idx;
    bit  m_valid = 0;

    function automatic void model_step(input bit sr, input bit rq, input logic [N-1:0] rdy);
        if (sr || rq) begin
            m_valid = 1; m_phase = P_HOLD; m_elapsed = 0; m_nrel = 0; m_idx = 0;
            return;
        end
        if (!m_valid) return;
        case (m_phase)
            P_HOLD: begin
                m_elapsed++;
                if (m_elapsed == HOLD) begin m_nrel = 1; m_phase = P_WAIT; m_elapsed = 0; end
            end
            P_WAIT: begin
                if (rdy[m_idx]) begin
                    m_elapsed = 0;
                    m_phase = (m_idx == N - 1) ? P_DONE : P_GAP;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == TIMEOUT) m_phase = P_ERR;
                end
            end
            P_GAP: begin
                m_elapsed++;
                if (m_elapsed == GAP) begin
                    m_idx++; m_nrel++; m_phase = P_WAIT; m_elapsed = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   r;
        r = 0;
        for (int i = 0; i < N; i++) if (i >= m_nrel) r = r | (1 << i);
        e.rst  = (m_phase == P_ERR) ? {N{1'b1}} : r[N-1:0];
        e.busy = (m_phase == P_HOLD) || (m_phase == P_WAIT) || (m_phase == P_GAP);
        e.done = (m_phase == P_DONE);
        e.err  = (m_phase == P_ERR);
        e.idx  = IW'(m_idx);
        return e;
    endfunction

    task automatic apply(input bit sr, input bit rq, input logic [N-1:0] rdy);
        #1;
        sync_rst = sr; req_rst = rq; domain_ready = rdy;
        @(posedge clk);
        model_step(sr, rq, rdy);
        if (m_valid) exp_q.push_back(model_out());
    endtask

    task automatic run(input int cycles, input logic [N-1:0] rdy);
        for (int i = 0; i < cycles; i++) apply(0, 0, rdy);
    endtask

    // Monitor: one expected entry per edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (rst_out !== e.rst || busy !== e.busy || done !== e.done ||
                    err !== e.err || seq_idx !== e.idx) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got rst=%b busy=%b done=%b err=%b idx=%0d exp rst=%b busy=%b done=%b err=%b idx=%0d",
                             $time, rst_out, busy, done, err, seq_idx,
                             e.rst, e.busy, e.done, e.err, e.idx);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rdy;
        int           pct;
        // Reset for 3 edges, hold with nothing ready
        for (int i = 0; i < 3; i++) apply(1, 0, '0);
        run(12, '0);
        // All domains ready: full release sequence to DONE
        run(25, 4'b1111);
        // Restart request in DONE replays the sequence
        apply(0, 1, 4'b1111);
        run(25, 4'b1111);
        // Domain 2 never ready: timeout into ERR, then hold
        apply(1, 0, 4'b1011);
        run(100, 4'b1011);
        // Reset and request together in ERR
        apply(1, 1, 4'b1011);
        // Sync reset in the middle of the first gap
        run(HOLD + 1 + 2, 4'b1111);
        apply(1, 0, 4'b1111);
        run(5, 4'b1111);
        // Restart request during hold extends it
        apply(0, 1, '0);
        run(HOLD + 1, 4'b0001);
        // WAIT_RDY on domain 1: other ready bits ignored, then domain 1 acks
        run(GAP + 3, 4'b0001);
        apply(0, 0, 4'b1000);
        apply(0, 0, 4'b1001);
        run(3, '0);
        apply(0, 0, 4'b0010);
        run(GAP + 2, '0);
        // Randomized stretch with varying ready density and occasional restarts
        for (int blk = 0; blk < 20; blk++) begin
            pct = $urandom_range(2, 60);
            for (int c = 0; c < 150; c++) begin
                for (int b = 0; b < N; b++) rdy[b] = ($urandom_range(0, 99) < pct);
                apply($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0, rdy);
            end
        end
        apply(0, 0, '0);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending entries, exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
